if_id_stage: RTL and testbench

Fetch-side pipeline stage. Holds the PC register and the IF/ID pipeline register, and sits directly downstream of the hazard detection unit, consuming its 2-bit Stall vector.
- On a stall it freezes PC and IF/ID and requests a bubble into ID/EX.
- On a branch/jump redirect resolved in ID it loads the target and squashes the wrong-path fetch.
- It also keeps saturating stall/flush performance counters and a stall-timeout watchdog.

---
 rtl/if_id_stage_pkg.sv | 16 +
 rtl/if_id_stage_if.sv | 34 +++
 rtl/if_id_stage_sat_counter.sv | 31 +++
 rtl/if_id_stage.sv | 103 ++++++++++
 tb/tb_if_id_stage.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the fetch stage: default reset PC, the NOP encoding
// injected on flush/reset, bit positions inside the hazard unit's Stall vector,
// and a helper that forces word alignment of a redirect target.
package if_id_stage_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  localparam int unsigned STALL_EX_BIT = 1;
  localparam int unsigned STALL_ID_BIT = 0;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Bus between the hazard unit / branch resolver / instruction memory and the
// fetch stage.
//   master: drives Stall, redirect_valid, redirect_pc, imem_inst
//   slave : the fetch stage; drives PC, IF/ID contents, flush request,
//           performance counters and sticky error flags
interface if_id_stage_if #(
  parameter int unsigned CNT_W = 16
);
  logic [1:0]       Stall;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [31:0]      imem_inst;
  logic [31:0]      pc_out;
  logic [31:0]      IF_ID_PC;
  logic [31:0]      IF_ID_inst;
  logic             IF_ID_valid;
  logic             ID_EX_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             stall_timeout;
  logic             misalign_err;

  modport master (
    output Stall, redirect_valid, redirect_pc, imem_inst,
    input  pc_out, IF_ID_PC, IF_ID_inst, IF_ID_valid, ID_EX_flush,
           stall_cnt, flush_cnt, stall_timeout, misalign_err
  );

  modport slave (
    input  Stall, redirect_valid, redirect_pc, imem_inst,
    output pc_out, IF_ID_PC, IF_ID_inst, IF_ID_valid, ID_EX_flush,
           stall_cnt, flush_cnt, stall_timeout, misalign_err
  );
endinterface

// File: rtl/if_id_stage_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : clear to zero (wins over i_inc)
//   i_inc      : increment by one unless already at MAX
//   o_count    : current count
module if_id_stage_sat_counter #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MAX)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/if_id_stage.sv
// Fetch-side pipeline stage: PC register plus IF/ID pipeline register.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : slave side of if_id_stage_if (stall vector, redirect, imem
//               data in; PC, IF/ID, ID/EX bubble request, counters, flags out)
// Per cycle: stall holds everything (redirect ignored), else a redirect loads
// the aligned target and squashes IF/ID, else sequential fetch.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST  = DEF_NOP_INST,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned STALL_MAX = 8
) (
  input logic          clk,
  input logic          rstn,
  if_id_stage_if.slave bus
);

  localparam int unsigned      RUN_W    = $clog2(STALL_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STALL_MAX);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STALL_MAX - 1);

  logic             w_stall;
  logic             w_redirect;
  logic [RUN_W-1:0] w_run_cnt;
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;

  logic [31:0] r_pc;
  logic [31:0] r_if_id_pc;
  logic [31:0] r_if_id_inst;
  logic        r_if_id_valid;
  logic        r_timeout;
  logic        r_misalign;

  assign w_stall    = bus.Stall[STALL_EX_BIT] | bus.Stall[STALL_ID_BIT];
  // A branch held in ID by a stall is unresolved, so its redirect is dropped.
  assign w_redirect = bus.redirect_valid & ~w_stall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc          <= RESET_PC;
      r_if_id_pc    <= '0;
      r_if_id_inst  <= NOP_INST;
      r_if_id_valid <= 1'b0;
    end else if (w_stall) begin
      r_pc          <= r_pc;
      r_if_id_pc    <= r_if_id_pc;
      r_if_id_inst  <= r_if_id_inst;
      r_if_id_valid <= r_if_id_valid;
    end else if (w_redirect) begin
      r_pc          <= align_word(bus.redirect_pc);
      r_if_id_pc    <= r_pc;
      r_if_id_inst  <= NOP_INST;
      r_if_id_valid <= 1'b0;
    end else begin
      r_pc          <= r_pc + 32'd4;
      r_if_id_pc    <= r_pc;
      r_if_id_inst  <= bus.imem_inst;
      r_if_id_valid <= 1'b1;
    end
  end

  // Sticky flags. The timeout sets on the edge that moves the run count
  // from STALL_MAX-1 to STALL_MAX.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_timeout  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      if (w_stall && (w_run_cnt == RUN_LAST)) begin
        r_timeout <= 1'b1;
      end
      if (w_redirect && (bus.redirect_pc[1:0] != 2'b00)) begin
        r_misalign <= 1'b1;
      end
    end
  end

  if_id_stage_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rstn), .i_clr(1'b0), .i_inc(w_stall), .o_count(w_stall_cnt)
  );

  if_id_stage_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rstn), .i_clr(1'b0), .i_inc(w_redirect), .o_count(w_flush_cnt)
  );

  if_id_stage_sat_counter #(.WIDTH(RUN_W), .MAX(RUN_MAX)) u_run_cnt (
    .clk(clk), .rst_n(rstn), .i_clr(~w_stall), .i_inc(w_stall), .o_count(w_run_cnt)
  );

  assign bus.pc_out        = r_pc;
  assign bus.IF_ID_PC      = r_if_id_pc;
  assign bus.IF_ID_inst    = r_if_id_inst;
  assign bus.IF_ID_valid   = r_if_id_valid;
  assign bus.ID_EX_flush   = w_stall;
  assign bus.stall_cnt     = w_stall_cnt;
  assign bus.flush_cnt     = w_flush_cnt;
  assign bus.stall_timeout = r_timeout;
  assign bus.misalign_err  = r_misalign;

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'h5A5A_0000;  // imem data = PC ^ KEY

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  if_id_stage_if #(.CNT_W(16)) bus ();

  if_id_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0013),
    .CNT_W    (16),
    .STALL_MAX(8)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  assign bus.imem_inst = bus.pc_out ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.Stall = 2'b00;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    #12;
    checks++; if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h exp %h", bus.pc_out, 32'h0); end
    checks++; if (bus.IF_ID_PC !== 32'h0) begin errors++; $display("FAIL rst_ifid_pc: got %h exp %h", bus.IF_ID_PC, 32'h0); end
    checks++; if (bus.IF_ID_inst !== NOP) begin errors++; $display("FAIL rst_inst: got %h exp %h", bus.IF_ID_inst, NOP); end
    checks++; if (bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", bus.IF_ID_valid); end
    checks++; if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnts: got %0d/%0d exp 0/0", bus.stall_cnt, bus.flush_cnt); end
    checks++; if (bus.stall_timeout !== 1'b0 || bus.misalign_err !== 1'b0) begin errors++; $display("FAIL rst_flags: got %b%b exp 00", bus.stall_timeout, bus.misalign_err); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_free_run();
    step();
    checks++; if (bus.pc_out !== 32'h4) begin errors++; $display("FAIL fr_pc1: got %h exp %h", bus.pc_out, 32'h4); end
    checks++; if (bus.IF_ID_PC !== 32'h0 || bus.IF_ID_inst !== (32'h0 ^ KEY)) begin errors++; $display("FAIL fr_ifid1: got %h/%h exp %h/%h", bus.IF_ID_PC, bus.IF_ID_inst, 32'h0, KEY); end
    checks++; if (bus.IF_ID_valid !== 1'b1) begin errors++; $display("FAIL fr_valid1: got %b exp 1", bus.IF_ID_valid); end
    step();
    checks++; if (bus.pc_out !== 32'h8) begin errors++; $display("FAIL fr_pc2: got %h exp %h", bus.pc_out, 32'h8); end
    checks++; if (bus.IF_ID_PC !== 32'h4 || bus.IF_ID_inst !== (32'h4 ^ KEY)) begin errors++; $display("FAIL fr_ifid2: got %h/%h exp %h/%h", bus.IF_ID_PC, bus.IF_ID_inst, 32'h4, 32'h4 ^ KEY); end
    checks++; if (bus.ID_EX_flush !== 1'b0) begin errors++; $display("FAIL fr_flush: got %b exp 0", bus.ID_EX_flush); end
  endtask

  task automatic test_stall_ex();
    bus.Stall = 2'b10;
    #1;
    checks++; if (bus.ID_EX_flush !== 1'b1) begin errors++; $display("FAIL st_flush: got %b exp 1", bus.ID_EX_flush); end
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'h8 || bus.IF_ID_PC !== 32'h4) begin errors++; $display("FAIL st_hold: got %h/%h exp %h/%h", bus.pc_out, bus.IF_ID_PC, 32'h8, 32'h4); end
    checks++; if (bus.IF_ID_inst !== (32'h4 ^ KEY)) begin errors++; $display("FAIL st_inst: got %h exp %h", bus.IF_ID_inst, 32'h4 ^ KEY); end
    checks++; if (bus.stall_cnt !== 16'd1) begin errors++; $display("FAIL st_cnt: got %0d exp 1", bus.stall_cnt); end
    bus.Stall = 2'b00;
    #1;
    checks++; if (bus.ID_EX_flush !== 1'b0) begin errors++; $display("FAIL st_unflush: got %b exp 0", bus.ID_EX_flush); end
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'hC || bus.IF_ID_PC !== 32'h8 || bus.IF_ID_inst !== (32'h8 ^ KEY)) begin errors++; $display("FAIL st_resume: got %h/%h/%h exp %h/%h/%h", bus.pc_out, bus.IF_ID_PC, bus.IF_ID_inst, 32'hC, 32'h8, 32'h8 ^ KEY); end
  endtask

  task automatic test_redirect();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    checks++; if (bus.pc_out !== 32'h100) begin errors++; $display("FAIL rd_pc: got %h exp %h", bus.pc_out, 32'h100); end
    checks++; if (bus.IF_ID_inst !== NOP || bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL rd_squash: got %h/%b exp %h/0", bus.IF_ID_inst, bus.IF_ID_valid, NOP); end
    checks++; if (bus.flush_cnt !== 16'd1) begin errors++; $display("FAIL rd_cnt: got %0d exp 1", bus.flush_cnt); end
    checks++; if (bus.misalign_err !== 1'b0) begin errors++; $display("FAIL rd_noalign: got %b exp 0", bus.misalign_err); end
    bus.redirect_valid = 1'b0;
    step();
    checks++; if (bus.IF_ID_PC !== 32'h100 || bus.IF_ID_valid !== 1'b1 || bus.pc_out !== 32'h104) begin errors++; $display("FAIL rd_after: got %h/%b/%h exp %h/1/%h", bus.IF_ID_PC, bus.IF_ID_valid, bus.pc_out, 32'h100, 32'h104); end
  endtask

  task automatic test_stall_redirect();
    bus.Stall = 2'b01;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    step();
    checks++; if (bus.pc_out !== 32'h104 || bus.IF_ID_valid !== 1'b1) begin errors++; $display("FAIL sr_hold: got %h/%b exp %h/1", bus.pc_out, bus.IF_ID_valid, 32'h104); end
    checks++; if (bus.flush_cnt !== 16'd1 || bus.stall_cnt !== 16'd2) begin errors++; $display("FAIL sr_cnts: got %0d/%0d exp 1/2", bus.flush_cnt, bus.stall_cnt); end
    bus.Stall = 2'b00;
    step();
    checks++; if (bus.pc_out !== 32'h200 || bus.flush_cnt !== 16'd2) begin errors++; $display("FAIL sr_take: got %h/%0d exp %h/2", bus.pc_out, bus.flush_cnt, 32'h200); end
    bus.redirect_valid = 1'b0;
    step();
    checks++; if (bus.pc_out !== 32'h204) begin errors++; $display("FAIL sr_next: got %h exp %h", bus.pc_out, 32'h204); end
  endtask

  task automatic test_timeout();
    // 7-cycle run, one free cycle, then an 8-cycle run
    bus.Stall = 2'b11;
    for (int i = 0; i < 7; i++) step();
    checks++; if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL to_run7: got %b exp 0", bus.stall_timeout); end
    checks++; if (bus.stall_cnt !== 16'd9) begin errors++; $display("FAIL to_cnt9: got %0d exp 9", bus.stall_cnt); end
    bus.Stall = 2'b00;
    step();
    bus.Stall = 2'b10;
    for (int i = 0; i < 7; i++) step();
    checks++; if (bus.stall_timeout !== 1'b0) begin errors++; $display("FAIL to_restart: got %b exp 0", bus.stall_timeout); end
    step();
    checks++; if (bus.stall_timeout !== 1'b1) begin errors++; $display("FAIL to_set: got %b exp 1", bus.stall_timeout); end
    checks++; if (bus.stall_cnt !== 16'd17 || bus.pc_out !== 32'h208) begin errors++; $display("FAIL to_state: got %0d/%h exp 17/%h", bus.stall_cnt, bus.pc_out, 32'h208); end
    bus.Stall = 2'b00;
    step();
    checks++; if (bus.stall_timeout !== 1'b1 || bus.pc_out !== 32'h20C) begin errors++; $display("FAIL to_sticky: got %b/%h exp 1/%h", bus.stall_timeout, bus.pc_out, 32'h20C); end
  endtask

  task automatic test_misalign();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h102;
    step();
    checks++; if (bus.pc_out !== 32'h100 || bus.misalign_err !== 1'b1) begin errors++; $display("FAIL ma_set: got %h/%b exp %h/1", bus.pc_out, bus.misalign_err, 32'h100); end
    checks++; if (bus.flush_cnt !== 16'd3) begin errors++; $display("FAIL ma_cnt: got %0d exp 3", bus.flush_cnt); end
    bus.redirect_valid = 1'b0;
    step();
    checks++; if (bus.misalign_err !== 1'b1 || bus.pc_out !== 32'h104) begin errors++; $display("FAIL ma_sticky: got %b/%h exp 1/%h", bus.misalign_err, bus.pc_out, 32'h104); end
  endtask

  task automatic test_pc_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    checks++; if (bus.pc_out !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_top: got %h exp %h", bus.pc_out, 32'hFFFF_FFFC); end
    bus.redirect_valid = 1'b0;
    step();
    checks++; if (bus.pc_out !== 32'h0 || bus.IF_ID_PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_wrap: got %h/%h exp %h/%h", bus.pc_out, bus.IF_ID_PC, 32'h0, 32'hFFFF_FFFC); end
  endtask

  task automatic test_async_reset();
    bus.Stall = 2'b01;
    step();
    checks++; if (bus.stall_cnt !== 16'd18) begin errors++; $display("FAIL ar_pre: got %0d exp 18", bus.stall_cnt); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (bus.pc_out !== 32'h0 || bus.IF_ID_inst !== NOP || bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL ar_pipe: got %h/%h/%b exp %h/%h/0", bus.pc_out, bus.IF_ID_inst, bus.IF_ID_valid, 32'h0, NOP); end
    checks++; if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin errors++; $display("FAIL ar_cnts: got %0d/%0d exp 0/0", bus.stall_cnt, bus.flush_cnt); end
    checks++; if (bus.stall_timeout !== 1'b0 || bus.misalign_err !== 1'b0) begin errors++; $display("FAIL ar_flags: got %b%b exp 00", bus.stall_timeout, bus.misalign_err); end
    @(negedge clk);
    rstn = 1'b1;
    bus.Stall = 2'b00;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h300;
    step();
    checks++; if (bus.pc_out !== 32'h300 || bus.flush_cnt !== 16'd1 || bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL ar_first_rd: got %h/%0d/%b exp %h/1/0", bus.pc_out, bus.flush_cnt, bus.IF_ID_valid, 32'h300); end
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_free_run();
    test_stall_ex();
    test_redirect();
    test_stall_redirect();
    test_timeout();
    test_misalign();
    test_pc_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
